// File: rtl/alu_result_collector.sv
// ALU result collector: FIFO with registered pop port, level tracking and sticky threshold interrupt.
// Optional running XOR checksum of accepted words enabled by ALU_RESULT_COLLECTOR_CHECKSUM_EN.
module alu_result_collector #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned THRESHOLD = 8
) (
    input  logic                     MCLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    input  logic [31:0]              IN_DATA,
    output logic                     IN_READY,
    input  logic                     RD_EN,
    output logic [31:0]              RD_DATA,
    output logic                     RD_VALID,
    output logic [$clog2(DEPTH):0]   LEVEL,
    input  logic                     INTR_CLR,
    output logic                     INTR,
`ifdef ALU_RESULT_COLLECTOR_CHECKSUM_EN
    output logic [31:0]              CHECKSUM,
`endif
    output logic                     BUSY
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW+1)'(THRESHOLD);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FULL
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW:0]   r_level;
    logic [AW:0]   w_level_next;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rd_data;
    logic          r_rd_valid;
    logic          r_intr;
    logic          r_above_q;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_above;
    logic          w_intr_set;

    // Full/empty come from the registered FSM state, so a pop never frees room for a same-cycle push.
    assign w_full     = (r_state == S_FULL);
    assign w_push     = IN_VALID && !w_full;
    assign w_pop      = RD_EN && (r_state != S_EMPTY);
    assign w_above    = (r_level >= THRESH_L);
    assign w_intr_set = w_above && !r_above_q;

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LVL_ONE;
        end
        unique case (r_state)
            S_EMPTY: if (w_push && !w_pop) w_state_next = S_FILL;
            S_FILL: begin
                if (w_push && !w_pop && (r_level == DEPTH_L - LVL_ONE)) w_state_next = S_FULL;
                else if (w_pop && !w_push && (r_level == LVL_ONE))     w_state_next = S_EMPTY;
            end
            S_FULL:  if (w_pop && !w_push) w_state_next = S_FILL;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_level    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_intr     <= 1'b0;
            r_above_q  <= 1'b0;
        end else begin
            r_level    <= w_level_next;
            r_rd_valid <= w_pop;
            r_above_q  <= w_above;
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) begin
                r_rptr    <= r_rptr + PTR_ONE;
                r_rd_data <= r_mem[r_rptr];
            end
            // Set takes priority over clear so a crossing is never lost.
            if (w_intr_set)    r_intr <= 1'b1;
            else if (INTR_CLR) r_intr <= 1'b0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (w_push) r_mem[r_wptr] <= IN_DATA;
    end

`ifdef ALU_RESULT_COLLECTOR_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum ^ IN_DATA;
        end
    end

    assign CHECKSUM = r_checksum;
`endif

    assign IN_READY = !w_full;
    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign LEVEL    = r_level;
    assign INTR     = r_intr;
    assign BUSY     = (r_level != '0) || r_rd_valid;

endmodule
